// File: rtl/sample_bus_arbiter.sv
// Round-robin arbiter/sequencer for the shared sample bus: grants one channel,
// strobes it, captures the returned word and pushes it into the sample FIFO.
// Optional macro SAMPLE_ARB_TIMESTAMP_EN appends a timestamp word per sample.
module sample_bus_arbiter #(
  parameter int NUM_CHANNELS = 16,
  parameter int CHAN_BASE    = 0,
  parameter int POSITION     = 242,
  parameter int DATA_W       = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_bus_en,
  input  logic                    cmd_bus_wr,
  input  logic [15:0]             cmd_bus_addr,
  input  logic [31:0]             cmd_bus_data,
  input  logic [NUM_CHANNELS-1:0] req,
  output logic [NUM_CHANNELS-1:0] grant,
  output logic                    output_sample,
  output logic [7:0]              channel_select,
  input  logic [DATA_W-1:0]       sample_data,
  output logic [DATA_W-1:0]       fifo_din,
  output logic                    fifo_wr_en,
  input  logic                    fifo_full,
  input  logic                    fifo_almost_full,
  output logic [15:0]             overflow_count,
  output logic                    busy
`ifdef SAMPLE_ARB_TIMESTAMP_EN
  ,input logic [31:0]             current_time
`endif
);

  localparam int PTR_W = $clog2(NUM_CHANNELS);
  localparam logic [15:0] MASK_ADDR = 16'(POSITION);
  localparam logic [15:0] CTRL_ADDR = 16'(POSITION + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_CHANNELS - 1);

`ifdef SAMPLE_ARB_TIMESTAMP_EN
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SELECT   = 3'd1,
    CAPTURE  = 3'd2,
    WRITE    = 3'd3,
    WRITE_TS = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SELECT  = 2'd1,
    CAPTURE = 2'd2,
    WRITE   = 2'd3
  } state_t;
`endif

  state_t                  state_r;
  logic [NUM_CHANNELS-1:0] mask_r;
  logic                    run_r;
  logic [PTR_W-1:0]        rr_ptr_r;
  logic [PTR_W-1:0]        gnt_idx_r;
  logic [15:0]             overflow_r;
  logic [DATA_W-1:0]       out_word_r;
  logic [NUM_CHANNELS-1:0] grant_r;
  logic                    strobe_r;
  logic [7:0]              chan_sel_r;
`ifdef SAMPLE_ARB_TIMESTAMP_EN
  logic [31:0]             ts_r;
`endif

  logic [NUM_CHANNELS-1:0] eligible_s;
  logic [PTR_W-1:0]        pick_idx_s;
  logic                    pick_valid_s;
  logic                    can_grant_s;
  logic                    mask_wr_s;
  logic                    ctrl_wr_s;
  logic                    write_state_s;
  logic                    unused_s;

  // First eligible index at or after ptr, wrapping; MSB flags that one exists.
  function automatic logic [PTR_W:0] rr_pick(input logic [PTR_W-1:0] ptr,
                                             input logic [NUM_CHANNELS-1:0] elig);
    logic [PTR_W:0]   result;
    logic [PTR_W-1:0] idx;
    int               sum;
    result = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      sum = int'(ptr) + i;
      if (sum >= NUM_CHANNELS) sum = sum - NUM_CHANNELS;
      else                     sum = sum;
      idx = PTR_W'(sum);
      if (elig[idx]) result = {1'b1, idx};
      else           result = result;
    end
    return result;
  endfunction

  // Eligibility, round-robin choice and command decode.
  always_comb begin
    eligible_s = req & mask_r;
    {pick_valid_s, pick_idx_s} = rr_pick(rr_ptr_r, eligible_s);
    can_grant_s = run_r & pick_valid_s & ~fifo_almost_full;
    mask_wr_s   = cmd_bus_en & cmd_bus_wr & (cmd_bus_addr == MASK_ADDR);
    ctrl_wr_s   = cmd_bus_en & cmd_bus_wr & (cmd_bus_addr == CTRL_ADDR);
`ifdef SAMPLE_ARB_TIMESTAMP_EN
    write_state_s = (state_r == WRITE) | (state_r == WRITE_TS);
`else
    write_state_s = (state_r == WRITE);
`endif
  end

  assign unused_s       = ^cmd_bus_data;
  assign grant          = grant_r;
  assign output_sample  = strobe_r;
  assign channel_select = chan_sel_r;
  assign fifo_din       = out_word_r;
  // The write decision follows fifo_full as seen during the write cycle itself.
  assign fifo_wr_en     = write_state_s & ~fifo_full;
  assign overflow_count = overflow_r;
  assign busy           = (state_r != IDLE);

  // Host-visible configuration and the saturating overflow counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_r     <= '0;
      run_r      <= 1'b0;
      overflow_r <= 16'h0000;
    end else begin
      if (mask_wr_s) mask_r <= cmd_bus_data[NUM_CHANNELS-1:0];
      if (ctrl_wr_s) run_r  <= cmd_bus_data[0];
      if (ctrl_wr_s && cmd_bus_data[1])
        overflow_r <= 16'h0000;
      else if (write_state_s && fifo_full && (overflow_r != 16'hFFFF))
        overflow_r <= overflow_r + 16'h0001;
    end
  end

  // Transaction sequencer: IDLE -> SELECT -> CAPTURE -> WRITE (-> WRITE_TS).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      rr_ptr_r   <= '0;
      gnt_idx_r  <= '0;
      grant_r    <= '0;
      strobe_r   <= 1'b0;
      chan_sel_r <= 8'h00;
      out_word_r <= '0;
`ifdef SAMPLE_ARB_TIMESTAMP_EN
      ts_r       <= 32'h0000_0000;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (can_grant_s) begin
            state_r    <= SELECT;
            gnt_idx_r  <= pick_idx_s;
            strobe_r   <= 1'b1;
            grant_r    <= {{(NUM_CHANNELS-1){1'b0}}, 1'b1} << pick_idx_s;
            chan_sel_r <= 8'(CHAN_BASE + int'(pick_idx_s));
          end else begin
            strobe_r <= 1'b0;
            grant_r  <= '0;
          end
        end
        SELECT: begin
          strobe_r <= 1'b0;
          grant_r  <= '0;
          rr_ptr_r <= (gnt_idx_r == LAST_IDX) ? '0 : gnt_idx_r + PTR_W'(1);
`ifdef SAMPLE_ARB_TIMESTAMP_EN
          ts_r     <= current_time;
`endif
          state_r  <= CAPTURE;
        end
        CAPTURE: begin
          out_word_r <= sample_data;
          state_r    <= WRITE;
        end
        WRITE: begin
`ifdef SAMPLE_ARB_TIMESTAMP_EN
          out_word_r <= DATA_W'(ts_r);
          state_r    <= WRITE_TS;
`else
          state_r    <= IDLE;
`endif
        end
`ifdef SAMPLE_ARB_TIMESTAMP_EN
        WRITE_TS: begin
          state_r <= IDLE;
        end
`endif
        default: begin
          state_r  <= IDLE;
          strobe_r <= 1'b0;
          grant_r  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_bus_arbiter.sv
// Directed bench for sample_bus_arbiter: a cycle table for round-robin
// alternation plus hand-written sequences for wrap, overflow, almost-full and reset.
module tb_sample_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_bus_en, cmd_bus_wr;
  logic [15:0] cmd_bus_addr;
  logic [31:0] cmd_bus_data;
  logic [15:0] req, grant;
  logic        output_sample;
  logic [7:0]  channel_select;
  logic [31:0] sample_data, fifo_din;
  logic        fifo_wr_en, fifo_full, fifo_almost_full;
  logic [15:0] overflow_count;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  sample_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .cmd_bus_en(cmd_bus_en), .cmd_bus_wr(cmd_bus_wr),
    .cmd_bus_addr(cmd_bus_addr), .cmd_bus_data(cmd_bus_data),
    .req(req), .grant(grant), .output_sample(output_sample),
    .channel_select(channel_select), .sample_data(sample_data),
    .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
    .fifo_almost_full(fifo_almost_full), .overflow_count(overflow_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] req;
    logic [31:0] sdata;
    logic        os;
    logic [15:0] grant;
    logic [7:0]  cs;
    logic        wr;
    logic [31:0] din;
    logic        busy;
  } vec_t;

  vec_t vecs[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmd_write(input logic [15:0] addr, input logic [31:0] data);
    cmd_bus_en   = 1'b1;
    cmd_bus_wr   = 1'b1;
    cmd_bus_addr = addr;
    cmd_bus_data = data;
    tick();
    cmd_bus_en   = 1'b0;
    cmd_bus_wr   = 1'b0;
    cmd_bus_addr = 16'h0000;
    cmd_bus_data = 32'h0;
  endtask

  // One complete transaction starting from IDLE with req_v presented.
  task automatic do_txn(input string name, input logic [15:0] req_v, input logic [31:0] sd,
                        input logic full_v, input int ch);
    logic [15:0] g;
    g = 16'h0001 << ch;
    req = req_v;
    tick();
    chk({name, " select"}, {output_sample, grant, channel_select, busy},
        {1'b1, g, 8'(ch), 1'b1});
    req = 16'h0000;
    tick();
    chk({name, " capture"}, {output_sample, grant, channel_select, fifo_wr_en},
        {1'b0, 16'h0000, 8'(ch), 1'b0});
    sample_data = sd;
    fifo_full   = full_v;
    tick();
    if (full_v) chk({name, " write dropped"}, {fifo_wr_en, busy}, {1'b0, 1'b1});
    else        chk({name, " write"}, {fifo_wr_en, fifo_din, busy}, {1'b1, sd, 1'b1});
    sample_data = 32'h0;
    tick();
    fifo_full = 1'b0;
    chk({name, " idle"}, {busy, fifo_wr_en, output_sample}, {1'b0, 1'b0, 1'b0});
  endtask

  initial begin
    vecs[0]  = '{16'h0005, 32'h0,        1'b1, 16'h0001, 8'd0, 1'b0, 32'h0,        1'b1};
    vecs[1]  = '{16'h0004, 32'h0,        1'b0, 16'h0000, 8'd0, 1'b0, 32'h0,        1'b1};
    vecs[2]  = '{16'h0004, 32'h11111111, 1'b0, 16'h0000, 8'd0, 1'b1, 32'h11111111, 1'b1};
    vecs[3]  = '{16'h0005, 32'h0,        1'b0, 16'h0000, 8'd0, 1'b0, 32'h11111111, 1'b0};
    vecs[4]  = '{16'h0005, 32'h0,        1'b1, 16'h0004, 8'd2, 1'b0, 32'h11111111, 1'b1};
    vecs[5]  = '{16'h0001, 32'h0,        1'b0, 16'h0000, 8'd2, 1'b0, 32'h11111111, 1'b1};
    vecs[6]  = '{16'h0001, 32'h22222222, 1'b0, 16'h0000, 8'd2, 1'b1, 32'h22222222, 1'b1};
    vecs[7]  = '{16'h0005, 32'h0,        1'b0, 16'h0000, 8'd2, 1'b0, 32'h22222222, 1'b0};
    vecs[8]  = '{16'h0005, 32'h0,        1'b1, 16'h0001, 8'd0, 1'b0, 32'h22222222, 1'b1};
    vecs[9]  = '{16'h0004, 32'h0,        1'b0, 16'h0000, 8'd0, 1'b0, 32'h22222222, 1'b1};
    vecs[10] = '{16'h0004, 32'h33333333, 1'b0, 16'h0000, 8'd0, 1'b1, 32'h33333333, 1'b1};
    vecs[11] = '{16'h0005, 32'h0,        1'b0, 16'h0000, 8'd0, 1'b0, 32'h33333333, 1'b0};
    vecs[12] = '{16'h0005, 32'h0,        1'b1, 16'h0004, 8'd2, 1'b0, 32'h33333333, 1'b1};
    vecs[13] = '{16'h0001, 32'h0,        1'b0, 16'h0000, 8'd2, 1'b0, 32'h33333333, 1'b1};
    vecs[14] = '{16'h0001, 32'h44444444, 1'b0, 16'h0000, 8'd2, 1'b1, 32'h44444444, 1'b1};
    vecs[15] = '{16'h0000, 32'h0,        1'b0, 16'h0000, 8'd2, 1'b0, 32'h44444444, 1'b0};

    rst = 1'b0;
    cmd_bus_en = 1'b0; cmd_bus_wr = 1'b0; cmd_bus_addr = 16'h0000; cmd_bus_data = 32'h0;
    req = 16'h0000; sample_data = 32'h0; fifo_full = 1'b0; fifo_almost_full = 1'b0;
    tick();
    tick();
    chk("reset outputs", {output_sample, grant, channel_select, fifo_wr_en, fifo_din, busy, overflow_count},
        {1'b0, 16'h0000, 8'h00, 1'b0, 32'h0, 1'b0, 16'h0000});
    rst = 1'b1;
    tick();

    // Round-robin alternation between ch0 and ch2.
    cmd_write(16'd242, 32'h0000_0005);
    cmd_write(16'd243, 32'h0000_0001);
    for (int i = 0; i < 16; i++) begin
      req         = vecs[i].req;
      sample_data = vecs[i].sdata;
      tick();
      chk($sformatf("rr vector %0d", i),
          {output_sample, grant, channel_select, fifo_wr_en, fifo_din, busy},
          {vecs[i].os, vecs[i].grant, vecs[i].cs, vecs[i].wr, vecs[i].din, vecs[i].busy});
    end
    req = 16'h0000; sample_data = 32'h0;

    // Pointer wrap: ch14 moves rr_ptr to 15, ch15 wraps it to 0.
    cmd_write(16'd242, 32'h0000_FFFF);
    do_txn("ch14", 16'h4000, 32'h0000_000A, 1'b0, 14);
    do_txn("ch15", 16'h8000, 32'h0000_000B, 1'b0, 15);
    do_txn("wrap ch0", 16'h8001, 32'h0000_000C, 1'b0, 0);

    // Drops on a full FIFO.
    do_txn("full ch1", 16'h0002, 32'h0000_0D01, 1'b1, 1);
    do_txn("full ch2", 16'h0004, 32'h0000_0D02, 1'b1, 2);
    do_txn("full ch3", 16'h0008, 32'h0000_0D03, 1'b1, 3);
    chk("overflow count 3", overflow_count, 16'd3);
    cmd_write(16'd243, 32'h0000_0002);
    chk("overflow cleared", overflow_count, 16'd0);
    cmd_write(16'd243, 32'h0000_0001);

    // Almost-full holds off grants.
    fifo_almost_full = 1'b1;
    req = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("almost full hold %0d", i), {output_sample, busy}, {1'b0, 1'b0});
    end
    fifo_almost_full = 1'b0;
    do_txn("after almost full ch4", 16'h0010, 32'h0000_0055, 1'b0, 4);

    do_txn("deadbeef ch3", 16'h0008, 32'hDEADBEEF, 1'b0, 3);

    // Masked channel is never granted.
    cmd_write(16'd242, 32'h0000_FFF7);
    req = 16'h0008;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("masked ch3 %0d", i), {output_sample, busy}, {1'b0, 1'b0});
    end
    req = 16'h0000;
    cmd_write(16'd242, 32'h0000_FFFF);

    // Asynchronous reset in CAPTURE with non-zero state everywhere.
    do_txn("pre-reset drop ch1", 16'h0002, 32'h0000_0077, 1'b1, 1);
    chk("pre-reset overflow", overflow_count, 16'd1);
    req = 16'h0004;
    tick();
    req = 16'h0000;
    tick();
    chk("in capture before reset", {busy, channel_select}, {1'b1, 8'd2});
    #2 rst = 1'b0;
    #1;
    chk("async reset outputs", {output_sample, grant, channel_select, fifo_wr_en, fifo_din, busy, overflow_count},
        {1'b0, 16'h0000, 8'h00, 1'b0, 32'h0, 1'b0, 16'h0000});
    #2 rst = 1'b1;
    tick();
    cmd_write(16'd242, 32'h0000_FFFF);
    req = 16'h0002;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("run off after reset %0d", i), {output_sample, busy}, {1'b0, 1'b0});
    end
    cmd_write(16'd243, 32'h0000_0001);
    do_txn("after reset ch1", 16'h0002, 32'h0000_0099, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
